axi_lite_regfile_slave: RTL and testbench
=========================================

Name: axi_lite_regfile_slave

Overview:
AXI4-Lite slave front end that converts bus transactions into the single-cycle write strobe and combinational read-address interface of the configuration register file. It sits between the processor-side AXI-Lite interconnect and the register file that holds res_x/res_y. Write and read channels are handled by two independent FSMs, one outstanding transaction each.

Parameters:
AXI_ADDR_WIDTH, 6, AXI byte-address width; must be >= REG_ADDR_WIDTH+2.
REG_ADDR_WIDTH, 4, register index width (register file depth = 2**REG_ADDR_WIDTH).
DATA_WIDTH, 32, data width; WSTRB width = DATA_WIDTH/8.

Ports:
clk  in  1  single system clock, all logic on posedge.
resetn  in  1  asynchronous, active-low reset.
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
s_axi_awvalid  in  1  write-address valid.
s_axi_awready  out  1  write-address ready.
s_axi_wdata  in  DATA_WIDTH  write data.
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes.
s_axi_wvalid  in  1  write-data valid.
s_axi_wready  out  1  write-data ready.
s_axi_bresp  out  2  write response.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
s_axi_arvalid  in  1  read-address valid.
s_axi_arready  out  1  read-address ready.
s_axi_rdata  out  DATA_WIDTH  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.
write_addr  out  REG_ADDR_WIDTH  register index to write.
write_data  out  DATA_WIDTH  data to write.
write_en  out  1  one-cycle write strobe.
read_addr  out  REG_ADDR_WIDTH  register index to read.
read_data  in  DATA_WIDTH  combinational read data from register file.

Behaviour:
- Reset (resetn low, async): both FSMs to IDLE; bvalid=rvalid=write_en=0; bresp=rresp=OKAY; rdata=0; write_addr/write_data/read_addr=0; aw/w capture flags cleared.
- Address decode: index = addr[REG_ADDR_WIDTH+1:2]; addr[1:0] ignored. Any nonzero bit above REG_ADDR_WIDTH+1 is out of range.
- Write FSM W_IDLE/W_EXEC/W_RESP:
  - W_IDLE: awready = !aw_captured, wready = !w_captured (combinational). AW and W are accepted independently, in either order or in the same cycle; each is latched on its handshake.
  - Both captured -> W_EXEC. write_en=1 for exactly one cycle only if the address is in range and wstrb is all ones; otherwise write_en stays 0 and the response is SLVERR (2'b10). Partial strobes are never written.
  - W_EXEC -> W_RESP: bvalid=1, bresp held stable until bready; on the handshake cycle -> W_IDLE with flags cleared. bready already high gives a one-cycle W_RESP.
  - Minimum latency: AW+W handshake at cycle N, write_en at N+1, bvalid at N+2.
- Read FSM R_IDLE/R_FETCH/R_RESP:
  - R_IDLE: arready=1. On handshake, latch the index into read_addr -> R_FETCH.
  - R_FETCH: sample read_data into rdata; rresp=OKAY. If out of range: rdata=0, rresp=SLVERR. -> R_RESP.
  - R_RESP: rvalid=1, rdata/rresp held until rready -> R_IDLE.
  - Latency: AR handshake at N, rvalid at N+2.
- Simultaneous read and write to the same index:
  - If write_en and R_FETCH coincide, the read returns the old value, because the register file updates at that edge.
  - A read fetched in a later cycle returns the new value.
- Reset mid-transaction abandons the transaction. No write_en is issued after resetn deasserts for a pre-reset transaction.
- Valid signals never depend combinationally on ready inputs.

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp_t with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - enums wr_state_t {W_IDLE, W_EXEC, W_RESP} and rd_state_t {R_IDLE, R_FETCH, R_RESP}.
- No sub-module. Write and read channels are two always_ff FSM processes in this module; the register file is instantiated alongside it by the parent.

Test Plan:
- AW(0x04) and W(0x00000280, strb 0xF) in the same cycle, bready=1 -> write_en at N+1 with write_addr=1 and write_data=0x280; bvalid at N+2 with bresp=OKAY.
- W(0x1E0) two cycles before AW(0x00) -> wready drops after the W handshake; write_en only after the AW handshake with write_addr=0; single bvalid.
- Write strb=0x3 to 0x08 -> no write_en, bresp=SLVERR. Write to addr 0x40 (out of range) -> no write_en, bresp=SLVERR. A subsequent read of 0x08 returns the prior value.
- Read 0x04 with register 1=0x280 and rready held low for 5 cycles -> rvalid at N+2, rdata=0x280 and rresp=OKAY stable until rready; arready low throughout.
- Concurrent write to 0x00 (0xAAAA) with write_en coinciding with R_FETCH of 0x00 (old value 0x5555) -> rdata=0x5555; a following read returns 0xAAAA.
- resetn pulsed low while in W_RESP and R_RESP -> bvalid=rvalid=0 immediately; next write completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register-file front end.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave converting bus writes into a one-cycle register-file strobe
// and bus reads into a registered fetch of the combinational read port.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      write_en,
    output logic [REG_ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0]     read_data
);

    // Bits above the register index must all be zero for a valid access.
    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr >> (REG_ADDR_WIDTH + 2)) == '0;
    endfunction

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic  aw_captured, w_captured;
    logic  aw_ok, strb_ok, ar_ok;
    logic  aw_hs, w_hs, ar_hs;
    resp_t bresp_q, rresp_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    assign s_axi_bresp = bresp_q;
    assign s_axi_rresp = rresp_q;

    // Write channel: state register, next state, outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_captured || aw_hs) && (w_captured || w_hs)) w_next = W_EXEC;
            W_EXEC:  w_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = (w_state == W_IDLE) && !aw_captured;
        s_axi_wready  = (w_state == W_IDLE) && !w_captured;
        write_en      = (w_state == W_EXEC) && aw_ok && strb_ok;
        s_axi_bvalid  = (w_state == W_RESP);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            aw_ok       <= 1'b0;
            strb_ok     <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            bresp_q     <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_captured <= 1'b1;
                write_addr  <= s_axi_awaddr[REG_ADDR_WIDTH+1:2];
                aw_ok       <= in_range(s_axi_awaddr);
            end
            if (w_hs) begin
                w_captured <= 1'b1;
                write_data <= s_axi_wdata;
                strb_ok    <= &s_axi_wstrb;
            end
            if (w_state == W_EXEC)
                bresp_q <= (aw_ok && strb_ok) ? RESP_OKAY : RESP_SLVERR;
            if (w_state == W_RESP && s_axi_bready) begin
                aw_captured <= 1'b0;
                w_captured  <= 1'b0;
            end
        end
    end

    // Read channel: state register, next state, outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: r_next = R_RESP;
            R_RESP:  if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (r_state == R_IDLE);
        s_axi_rvalid  = (r_state == R_RESP);
    end

    // Fetch samples read_data before any coincident register-file write lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            read_addr   <= '0;
            ar_ok       <= 1'b0;
            s_axi_rdata <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                read_addr <= s_axi_araddr[REG_ADDR_WIDTH+1:2];
                ar_ok     <= in_range(s_axi_araddr);
            end
            if (r_state == R_FETCH) begin
                s_axi_rdata <= ar_ok ? read_data : '0;
                rresp_q     <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave with a small register file attached.
module tb_axi_lite_regfile_slave;
    import axi_lite_pkg::*;

    logic        clk;
    logic        resetn;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [3:0]  write_addr, read_addr;
    logic [31:0] write_data, read_data;
    logic        write_en;

    logic [31:0] regs [16];
    int          we_count;
    int          passed, total;

    axi_lite_regfile_slave #(
        .AXI_ADDR_WIDTH(8),
        .REG_ADDR_WIDTH(4),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
        .read_addr(read_addr), .read_data(read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (write_en) begin
            regs[write_addr] <= write_data;
        end
    end
    assign read_data = regs[read_addr];

    initial we_count = 0;
    always @(posedge clk) if (write_en) we_count <= we_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic exp_we, input logic [3:0] exp_idx, input logic [1:0] exp_resp);
        int we0;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
        check("awready_idle", 32'(awready), 32'd1);
        check("wready_idle", 32'(wready), 32'd1);
        we0 = we_count;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("write_en_n1", 32'(write_en), 32'(exp_we));
        if (exp_we) begin
            check("write_addr", 32'(write_addr), 32'(exp_idx));
            check("write_data", write_data, data);
        end
        check("bvalid_n1", 32'(bvalid), 32'd0);
        @(negedge clk);
        check("bvalid_n2", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'(exp_resp));
        @(negedge clk);
        check("bvalid_done", 32'(bvalid), 32'd0);
        check("we_pulses", 32'(we_count - we0), 32'(exp_we));
    endtask

    task automatic do_read(input logic [7:0] addr, input int hold,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        check("arready_idle", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_n1", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("rvalid_n2", 32'(rvalid), 32'd1);
        check("rdata", rdata, exp_data);
        check("rresp", 32'(rresp), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, exp_data);
            check("rresp_hold", 32'(rresp), 32'(exp_resp));
            check("arready_hold", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_done", 32'(rvalid), 32'd0);
    endtask

    initial begin
        int we0;
        passed = 0; total = 0;
        resetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bresp", 32'(bresp), 32'(RESP_OKAY));
        check("rst_rresp", 32'(rresp), 32'(RESP_OKAY));
        check("rst_write_addr", 32'(write_addr), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_read_addr", 32'(read_addr), 32'd0);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        resetn = 1'b1;

        // AW and W together
        do_write(8'h04, 32'h0000_0280, 4'hF, 1'b1, 4'd1, RESP_OKAY);

        // W two cycles ahead of AW
        @(negedge clk);
        wdata = 32'h1E0; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        we0 = we_count;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_first_wready", 32'(wready), 32'd0);
        check("w_first_awready", 32'(awready), 32'd1);
        check("w_first_no_we", 32'(write_en), 32'd0);
        @(negedge clk);
        check("w_first_no_we2", 32'(write_en), 32'd0);
        awaddr = 8'h00; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("w_first_we", 32'(write_en), 32'd1);
        check("w_first_addr", 32'(write_addr), 32'd0);
        check("w_first_data", write_data, 32'h1E0);
        @(negedge clk);
        check("w_first_bvalid", 32'(bvalid), 32'd1);
        check("w_first_bresp", 32'(bresp), 32'(RESP_OKAY));
        @(negedge clk);
        check("w_first_bdone", 32'(bvalid), 32'd0);
        check("w_first_pulses", 32'(we_count - we0), 32'd1);

        // Partial strobe and out-of-range writes are rejected
        do_write(8'h08, 32'h1234_5678, 4'hF, 1'b1, 4'd2, RESP_OKAY);
        do_write(8'h08, 32'h0000_FFFF, 4'h3, 1'b0, 4'd2, RESP_SLVERR);
        do_write(8'h40, 32'h0000_DEAD, 4'hF, 1'b0, 4'd0, RESP_SLVERR);
        do_read(8'h08, 0, 32'h1234_5678, RESP_OKAY);
        do_read(8'h00, 0, 32'h0000_01E0, RESP_OKAY);
        do_read(8'h40, 0, 32'h0, RESP_SLVERR);

        // Read with rready held low
        do_read(8'h04, 5, 32'h0000_0280, RESP_OKAY);

        // Write strobe coinciding with the read fetch of the same register
        do_write(8'h00, 32'h5555, 4'hF, 1'b1, 4'd0, RESP_OKAY);
        @(negedge clk);
        awaddr = 8'h00; wdata = 32'hAAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h00; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("race_we", 32'(write_en), 32'd1);
        check("race_fetch_arready", 32'(arready), 32'd0);
        @(negedge clk);
        check("race_rvalid", 32'(rvalid), 32'd1);
        check("race_rdata_old", rdata, 32'h5555);
        check("race_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("race_rdone", 32'(rvalid), 32'd0);
        check("race_bdone", 32'(bvalid), 32'd0);
        do_read(8'h00, 0, 32'hAAAA, RESP_OKAY);

        // Reset while both channels wait in their response states
        @(negedge clk);
        awaddr = 8'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h04; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // AW captured alone, then reset: no write may follow
        @(negedge clk);
        awaddr = 8'h10; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("aw_only_awready", 32'(awready), 32'd0);
        #1 resetn = 1'b0;
        #1 check("aw_only_rst_awready", 32'(awready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        we0 = we_count;
        repeat (3) @(negedge clk);
        check("aw_only_no_we", 32'(we_count - we0), 32'd0);

        // Normal traffic after reset
        do_write(8'h0C, 32'hCAFE_F00D, 4'hF, 1'b1, 4'd3, RESP_OKAY);
        do_read(8'h0C, 1, 32'hCAFE_F00D, RESP_OKAY);
        do_read(8'h04, 0, 32'h0, RESP_OKAY);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
